// File: rtl/mcpu_core_rf_scoreboard_pkg.sv
// Shared constants, scoreboard FSM encoding and lane-slice helpers for the
// register-file scoreboard.
package mcpu_core_rf_scoreboard_pkg;

  localparam int NLANES = 4;
  localparam int NREGS  = 32;
  localparam int NPREDS = 3;
  localparam int REG_W  = 5;
  localparam int PRED_W = 2;

  // Predicate number 3 is reserved for "no predicate / always".
  localparam logic [PRED_W-1:0] PRED_NONE = 2'd3;

  typedef logic [1:0] sb_state_t;
  localparam sb_state_t SB_RUN   = 2'd0;
  localparam sb_state_t SB_DRAIN = 2'd1;
  localparam sb_state_t SB_DONE  = 2'd2;

  function automatic logic [REG_W-1:0] reg_slice(
    input logic [NLANES*REG_W-1:0] vec,
    input int                      lane
  );
    return vec[lane*REG_W +: REG_W];
  endfunction

  function automatic logic [PRED_W-1:0] pred_slice(
    input logic [NLANES*PRED_W-1:0] vec,
    input int                       lane
  );
    return vec[lane*PRED_W +: PRED_W];
  endfunction

endpackage

// File: rtl/mcpu_core_sb_lane_decode.sv
// Turns a set of per-lane register numbers plus GPR/predicate enables into a
// one-hot-per-register GPR mask and predicate mask.
module mcpu_core_sb_lane_decode
  import mcpu_core_rf_scoreboard_pkg::*;
(
  input  logic [NLANES*REG_W-1:0] num_i,
  input  logic [NLANES-1:0]       gpr_we_i,
  input  logic [NLANES-1:0]       pred_we_i,
  output logic [NREGS-1:0]        gpr_mask_o,
  output logic [NPREDS-1:0]       pred_mask_o
);

  genvar gi;

  for (gi = 0; gi < NREGS; gi++) begin : g_gpr
    logic [NLANES-1:0] hit;
    always_comb begin
      hit = '0;
      for (int l = 0; l < NLANES; l++) begin
        hit[l] = gpr_we_i[l] & (reg_slice(num_i, l) == REG_W'(gi));
      end
    end
    assign gpr_mask_o[gi] = |hit;
  end

  // Predicate number is the low bits of rd; index 3 never matches any gi.
  for (gi = 0; gi < NPREDS; gi++) begin : g_pred
    logic [NLANES-1:0] hit;
    always_comb begin
      hit = '0;
      for (int l = 0; l < NLANES; l++) begin
        hit[l] = pred_we_i[l] &
                 (num_i[l*REG_W +: PRED_W] == PRED_W'(gi));
      end
    end
    assign pred_mask_o[gi] = |hit;
  end

endmodule

// File: rtl/mcpu_core_rf_scoreboard.sv
// Issue-stage scoreboard: one pending bit per GPR and predicate, all-or-nothing
// bundle stall on RAW/WAW hazards, plus flush and drain sequencing.
module mcpu_core_rf_scoreboard
  import mcpu_core_rf_scoreboard_pkg::*;
#(
  parameter int WB_BYPASS   = 1,
  parameter int STALL_CNT_W = 32
) (
  input  logic                     clkrst_core_clk,
  input  logic                     clkrst_core_rst,
  input  logic                     d2sb_valid,
  input  logic [NLANES-1:0]        d2sb_lane_valid,
  input  logic [NLANES*REG_W-1:0]  d2sb_rs_num,
  input  logic [NLANES*REG_W-1:0]  d2sb_rt_num,
  input  logic [NLANES*REG_W-1:0]  d2sb_rd_num,
  input  logic [NLANES-1:0]        d2sb_rs_use,
  input  logic [NLANES-1:0]        d2sb_rt_use,
  input  logic [NLANES-1:0]        d2sb_rd_we,
  input  logic [NLANES-1:0]        d2sb_pred_we,
  input  logic [NLANES*PRED_W-1:0] d2sb_pred_num,
  output logic                     sb2d_ready,
  input  logic [NLANES*REG_W-1:0]  wb2sb_rd_num,
  input  logic [NLANES-1:0]        wb2sb_rd_we,
  input  logic [NLANES-1:0]        wb2sb_pred_we,
  input  logic                     sb_flush,
  input  logic                     sb_drain_req,
  output logic                     sb2c_drain_done,
  output logic [NREGS-1:0]         sb_gpr_pending,
  output logic [NPREDS-1:0]        sb_pred_pending,
  output logic [STALL_CNT_W-1:0]   sb_stall_cycles
);

  logic [NREGS-1:0]       pend_q, pend_d, pend_eff;
  logic [NPREDS-1:0]      ppend_q, ppend_d, ppend_eff;
  logic [NPREDS:0]        ppend_eff_ext;
  logic [NREGS-1:0]       wb_gpr_clr, iss_gpr_set;
  logic [NPREDS-1:0]      wb_pred_clr, iss_pred_set;
  logic [NLANES-1:0]      lane_hazard;
  logic [NLANES-1:0]      iss_gpr_we, iss_pred_we;
  logic                   fire;
  logic                   stall_inc;
  sb_state_t              state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  mcpu_core_sb_lane_decode u_wb_decode (
    .num_i       (wb2sb_rd_num),
    .gpr_we_i    (wb2sb_rd_we),
    .pred_we_i   (wb2sb_pred_we),
    .gpr_mask_o  (wb_gpr_clr),
    .pred_mask_o (wb_pred_clr)
  );

  assign iss_gpr_we  = d2sb_rd_we   & d2sb_lane_valid & {NLANES{fire}};
  assign iss_pred_we = d2sb_pred_we & d2sb_lane_valid & {NLANES{fire}};

  mcpu_core_sb_lane_decode u_iss_decode (
    .num_i       (d2sb_rd_num),
    .gpr_we_i    (iss_gpr_we),
    .pred_we_i   (iss_pred_we),
    .gpr_mask_o  (iss_gpr_set),
    .pred_mask_o (iss_pred_set)
  );

  if (WB_BYPASS != 0) begin : g_bypass
    assign pend_eff  = pend_q  & ~wb_gpr_clr;
    assign ppend_eff = ppend_q & ~wb_pred_clr;
  end else begin : g_no_bypass
    assign pend_eff  = pend_q;
    assign ppend_eff = ppend_q;
  end

  // Extra always-zero entry so predicate index 3 can be looked up safely.
  assign ppend_eff_ext = {1'b0, ppend_eff};

  genvar gi;
  for (gi = 0; gi < NLANES; gi++) begin : g_lane
    logic [REG_W-1:0]  rs, rt, rd;
    logic [PRED_W-1:0] pn, pd;
    assign rs = reg_slice(d2sb_rs_num, gi);
    assign rt = reg_slice(d2sb_rt_num, gi);
    assign rd = reg_slice(d2sb_rd_num, gi);
    assign pn = pred_slice(d2sb_pred_num, gi);
    assign pd = rd[PRED_W-1:0];
    assign lane_hazard[gi] = d2sb_lane_valid[gi] & (
        (d2sb_rs_use[gi]  & pend_eff[rs])
      | (d2sb_rt_use[gi]  & pend_eff[rt])
      | (d2sb_rd_we[gi]   & pend_eff[rd])
      | (d2sb_pred_we[gi] & (pd != PRED_NONE) & ppend_eff_ext[pd])
      | ((pn != PRED_NONE) & ppend_eff_ext[pn]));
  end

  assign sb2d_ready = (state_q == SB_RUN) & ~sb_flush & ~|lane_hazard;
  assign fire       = d2sb_valid & sb2d_ready;

  // Set has priority over a same-cycle clear; flush overrides both.
  always_comb begin
    pend_d  = (pend_q  & ~wb_gpr_clr)  | iss_gpr_set;
    ppend_d = (ppend_q & ~wb_pred_clr) | iss_pred_set;
    if (sb_flush) begin
      pend_d  = '0;
      ppend_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN:   if (sb_drain_req) state_d = SB_DRAIN;
      SB_DRAIN: if (sb_flush || ((pend_q == '0) && (ppend_q == '0))) state_d = SB_DONE;
      SB_DONE:  if (!sb_drain_req) state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
  end

  assign stall_inc = (state_q == SB_RUN) & d2sb_valid & ~sb_flush & ~sb2d_ready;
  assign stall_d   = (stall_inc && (stall_q != '1)) ? stall_q + STALL_CNT_W'(1) : stall_q;

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      pend_q  <= '0;
      ppend_q <= '0;
      state_q <= SB_RUN;
      stall_q <= '0;
    end else begin
      pend_q  <= pend_d;
      ppend_q <= ppend_d;
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign sb2c_drain_done = (state_q == SB_DONE);
  assign sb_gpr_pending  = pend_q;
  assign sb_pred_pending = ppend_q;
  assign sb_stall_cycles = stall_q;

endmodule

// File: tb/tb_mcpu_core_rf_scoreboard.sv
// Randomised and directed bench for the register-file scoreboard against a
// per-register behavioural model of pending state, drain FSM and stall count.
module tb_mcpu_core_rf_scoreboard;

  localparam int WB_BYPASS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d2sb_valid;
  logic [3:0]  d2sb_lane_valid;
  logic [19:0] d2sb_rs_num, d2sb_rt_num, d2sb_rd_num;
  logic [3:0]  d2sb_rs_use, d2sb_rt_use, d2sb_rd_we, d2sb_pred_we;
  logic [7:0]  d2sb_pred_num;
  logic        sb2d_ready;
  logic [19:0] wb2sb_rd_num;
  logic [3:0]  wb2sb_rd_we, wb2sb_pred_we;
  logic        sb_flush, sb_drain_req;
  logic        sb2c_drain_done;
  logic [31:0] sb_gpr_pending;
  logic [2:0]  sb_pred_pending;
  logic [31:0] sb_stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: plain per-register flags, named drain phases, a counter.
  bit    m_pend[32];
  bit    m_ppend[3];
  string m_phase;
  longint unsigned m_stall;

  always #5 clk = ~clk;

  mcpu_core_rf_scoreboard #(.WB_BYPASS(WB_BYPASS), .STALL_CNT_W(32)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .d2sb_valid      (d2sb_valid),
    .d2sb_lane_valid (d2sb_lane_valid),
    .d2sb_rs_num     (d2sb_rs_num),
    .d2sb_rt_num     (d2sb_rt_num),
    .d2sb_rd_num     (d2sb_rd_num),
    .d2sb_rs_use     (d2sb_rs_use),
    .d2sb_rt_use     (d2sb_rt_use),
    .d2sb_rd_we      (d2sb_rd_we),
    .d2sb_pred_we    (d2sb_pred_we),
    .d2sb_pred_num   (d2sb_pred_num),
    .sb2d_ready      (sb2d_ready),
    .wb2sb_rd_num    (wb2sb_rd_num),
    .wb2sb_rd_we     (wb2sb_rd_we),
    .wb2sb_pred_we   (wb2sb_pred_we),
    .sb_flush        (sb_flush),
    .sb_drain_req    (sb_drain_req),
    .sb2c_drain_done (sb2c_drain_done),
    .sb_gpr_pending  (sb_gpr_pending),
    .sb_pred_pending (sb_pred_pending),
    .sb_stall_cycles (sb_stall_cycles)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    d2sb_valid = 0; d2sb_lane_valid = 0;
    d2sb_rs_num = 0; d2sb_rt_num = 0; d2sb_rd_num = 0;
    d2sb_rs_use = 0; d2sb_rt_use = 0; d2sb_rd_we = 0; d2sb_pred_we = 0;
    d2sb_pred_num = 8'hFF;
    wb2sb_rd_num = 0; wb2sb_rd_we = 0; wb2sb_pred_we = 0;
    sb_flush = 0;
  endtask

  task automatic set_lane(input int l, input int rs, input int rt, input int rd,
                          input bit rs_use, input bit rt_use, input bit rd_we,
                          input bit pred_we, input int pnum);
    d2sb_lane_valid[l]     = 1'b1;
    d2sb_rs_num[l*5 +: 5]  = 5'(rs);
    d2sb_rt_num[l*5 +: 5]  = 5'(rt);
    d2sb_rd_num[l*5 +: 5]  = 5'(rd);
    d2sb_rs_use[l]         = rs_use;
    d2sb_rt_use[l]         = rt_use;
    d2sb_rd_we[l]          = rd_we;
    d2sb_pred_we[l]        = pred_we;
    d2sb_pred_num[l*2 +: 2] = 2'(pnum);
  endtask

  task automatic set_wb(input int l, input int rd, input bit we, input bit pwe);
    wb2sb_rd_num[l*5 +: 5] = 5'(rd);
    wb2sb_rd_we[l]         = we;
    wb2sb_pred_we[l]       = pwe;
  endtask

  function automatic bit wb_clears_gpr(input int r);
    for (int l = 0; l < 4; l++)
      if (wb2sb_rd_we[l] && (int'(wb2sb_rd_num[l*5 +: 5]) == r)) return 1;
    return 0;
  endfunction

  function automatic bit wb_clears_pred(input int p);
    for (int l = 0; l < 4; l++)
      if (wb2sb_pred_we[l] && (int'(wb2sb_rd_num[l*5 +: 2]) == p)) return 1;
    return 0;
  endfunction

  function automatic bit busy_gpr(input int r);
    return m_pend[r] && !(WB_BYPASS != 0 && wb_clears_gpr(r));
  endfunction

  function automatic bit busy_pred(input int p);
    if (p == 3) return 0;
    return m_ppend[p] && !(WB_BYPASS != 0 && wb_clears_pred(p));
  endfunction

  function automatic bit model_ready();
    if (m_phase != "RUN" || sb_flush) return 0;
    for (int l = 0; l < 4; l++) begin
      int rs, rt, rd, pn;
      if (!d2sb_lane_valid[l]) continue;
      rs = int'(d2sb_rs_num[l*5 +: 5]);
      rt = int'(d2sb_rt_num[l*5 +: 5]);
      rd = int'(d2sb_rd_num[l*5 +: 5]);
      pn = int'(d2sb_pred_num[l*2 +: 2]);
      if (d2sb_rs_use[l] && busy_gpr(rs)) return 0;
      if (d2sb_rt_use[l] && busy_gpr(rt)) return 0;
      if (d2sb_rd_we[l] && busy_gpr(rd)) return 0;
      if (d2sb_pred_we[l] && busy_pred(rd % 4)) return 0;
      if (busy_pred(pn)) return 0;
    end
    return 1;
  endfunction

  function automatic logic [31:0] model_gpr_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic logic [31:0] model_pred_vec();
    logic [31:0] v = 0;
    for (int p = 0; p < 3; p++) v[p] = m_ppend[p];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    for (int p = 0; p < 3; p++) m_ppend[p] = 0;
    m_phase = "RUN";
    m_stall = 0;
  endtask

  task automatic model_update(input bit rdy);
    bit fire = d2sb_valid && rdy;
    bit all_idle = (model_gpr_vec() == 0) && (model_pred_vec() == 0);
    bit nxt_g[32];
    bit nxt_p[3];
    for (int r = 0; r < 32; r++) nxt_g[r] = m_pend[r] && !wb_clears_gpr(r);
    for (int p = 0; p < 3; p++)  nxt_p[p] = m_ppend[p] && !wb_clears_pred(p);
    if (fire) begin
      for (int l = 0; l < 4; l++) begin
        int rd = int'(d2sb_rd_num[l*5 +: 5]);
        if (!d2sb_lane_valid[l]) continue;
        if (d2sb_rd_we[l]) nxt_g[rd] = 1;
        if (d2sb_pred_we[l] && (rd % 4) != 3) nxt_p[rd % 4] = 1;
      end
    end
    if (sb_flush) begin
      for (int r = 0; r < 32; r++) nxt_g[r] = 0;
      for (int p = 0; p < 3; p++)  nxt_p[p] = 0;
    end
    if (m_phase == "RUN" && d2sb_valid && !sb_flush && !rdy && m_stall != 32'hFFFF_FFFF)
      m_stall++;
    if (m_phase == "RUN") begin
      if (sb_drain_req) m_phase = "DRAIN";
    end else if (m_phase == "DRAIN") begin
      if (sb_flush || all_idle) m_phase = "DONE";
    end else begin
      if (!sb_drain_req) m_phase = "RUN";
    end
    m_pend  = nxt_g;
    m_ppend = nxt_p;
  endtask

  // One clock: check combinational and registered outputs, then advance.
  task automatic step();
    bit exp_rdy;
    #1;
    exp_rdy = model_ready();
    check_val("ready", 32'(sb2d_ready), 32'(exp_rdy));
    check_val("gpr_pending", sb_gpr_pending, model_gpr_vec());
    check_val("pred_pending", 32'(sb_pred_pending), model_pred_vec());
    check_val("drain_done", 32'(sb2c_drain_done), 32'(m_phase == "DONE"));
    check_val("stall_cycles", sb_stall_cycles, 32'(m_stall));
    @(posedge clk);
    model_update(exp_rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    bit done_seen;
    clear_inputs();
    sb_drain_req = 0;
    @(negedge clk);
    do_reset();
    check_val("reset_ready", 32'(sb2d_ready), 32'd1);
    check_val("reset_pending", sb_gpr_pending, 32'd0);
    check_val("reset_stall", sb_stall_cycles, 32'd0);

    // RAW stall, then same-cycle writeback bypass releases it
    d2sb_valid = 1; set_lane(0, 0, 0, 5, 0, 0, 1, 0, 3); step();
    clear_inputs(); d2sb_valid = 1; set_lane(2, 5, 0, 0, 1, 0, 0, 0, 3);
    step(); step();
    check_val("raw_stall_count", sb_stall_cycles, 32'd2);
    set_wb(1, 5, 1, 0); step();
    $display("RAW: stall=%0d pending=%08h", sb_stall_cycles, sb_gpr_pending);

    // Predicate hazard
    clear_inputs(); d2sb_valid = 1; set_lane(0, 0, 0, 2, 0, 0, 0, 1, 3); step();
    clear_inputs(); d2sb_valid = 1; set_lane(1, 0, 0, 0, 0, 0, 0, 0, 2); step();
    clear_inputs(); d2sb_valid = 1; set_lane(1, 0, 0, 0, 0, 0, 0, 0, 3); step();
    check_val("pred2_pending", 32'(sb_pred_pending), 32'd4);
    clear_inputs(); set_wb(0, 2, 0, 1); step();
    clear_inputs(); d2sb_valid = 1; set_lane(0, 0, 0, 7, 0, 0, 0, 1, 3); step();
    check_val("pred_idx3_ignored", 32'(sb_pred_pending), 32'd0);
    $display("PRED: pred_pending=%0h", sb_pred_pending);

    // Set/clear collision on r9
    clear_inputs(); d2sb_valid = 1; set_lane(0, 0, 0, 9, 0, 0, 1, 0, 3); step();
    clear_inputs(); d2sb_valid = 1; set_lane(1, 0, 0, 9, 0, 0, 1, 0, 3); set_wb(2, 9, 1, 0); step();
    check_val("collision_r9", 32'(sb_gpr_pending[9]), 32'd1);
    clear_inputs(); set_wb(0, 9, 1, 0); step();
    $display("COLLIDE: pending=%08h", sb_gpr_pending);

    // WAW across lanes
    clear_inputs(); d2sb_valid = 1;
    set_lane(0, 0, 0, 4, 0, 0, 1, 0, 3); set_lane(3, 0, 0, 4, 0, 0, 1, 0, 3); step();
    check_val("waw_single_bit", sb_gpr_pending, 32'h0000_0010);
    clear_inputs(); set_wb(3, 4, 1, 0); step();
    check_val("waw_cleared", 32'(sb_gpr_pending[4]), 32'd0);
    $display("WAW: pending=%08h", sb_gpr_pending);

    // Flush
    clear_inputs(); d2sb_valid = 1;
    set_lane(0, 0, 0, 1, 0, 0, 1, 0, 3); set_lane(1, 0, 0, 2, 0, 0, 1, 0, 3);
    set_lane(2, 0, 0, 30, 0, 0, 1, 0, 3); set_lane(3, 0, 0, 0, 0, 0, 0, 1, 3); step();
    clear_inputs(); d2sb_valid = 1; sb_flush = 1; step();
    clear_inputs(); step();
    check_val("flush_gpr", sb_gpr_pending, 32'd0);
    $display("FLUSH: pending=%08h pred=%0h", sb_gpr_pending, sb_pred_pending);

    // Drain with r3 outstanding
    clear_inputs(); d2sb_valid = 1; set_lane(0, 0, 0, 3, 0, 0, 1, 0, 3); step();
    clear_inputs(); sb_drain_req = 1; step(); step(); step();
    set_wb(0, 3, 1, 0); step(); clear_inputs();
    done_seen = 0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      if (sb2c_drain_done) done_seen = 1; else step();
    end
    check_val("drain_done_timeout", 32'(done_seen), 32'd1);
    sb_drain_req = 0; step(); step();
    $display("DRAIN: done_seen=%0d ready=%0d", done_seen, sb2d_ready);

    // Reset while draining
    d2sb_valid = 1; set_lane(0, 0, 0, 6, 0, 0, 1, 0, 3); step();
    clear_inputs(); sb_drain_req = 1; step(); step();
    sb_drain_req = 0; do_reset(); #1;
    check_val("rst_drain_ready", 32'(sb2d_ready), 32'd1);
    check_val("rst_drain_pending", sb_gpr_pending, 32'd0);
    check_val("rst_drain_done", 32'(sb2c_drain_done), 32'd0);
    check_val("rst_drain_stall", sb_stall_cycles, 32'd0);
    $display("RESET-IN-DRAIN: ready=%0d", sb2d_ready);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      d2sb_valid = ($urandom_range(0, 9) < 7);
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 2) != 0)
          set_lane(l, $urandom_range(0, 7), $urandom_range(0, 7),
                   ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : 3);
        if ($urandom_range(0, 2) == 0)
          set_wb(l, $urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      end
      sb_flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) sb_drain_req = ~sb_drain_req;
      step();
      if (c % 100 == 0)
        $display("RAND %0d: ready=%0d pending=%08h pred=%0h stall=%0d",
                 c, sb2d_ready, sb_gpr_pending, sb_pred_pending, sb_stall_cycles);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
